// File: rtl/axis_red_pitaya_dac_pkg.sv
// axis_red_pitaya_dac_pkg: FSM state codes, idle DAC code and sample conversion helpers
package axis_red_pitaya_dac_pkg;

    localparam logic [1:0] ST_RST_HOLD = 2'd0;
    localparam logic [1:0] ST_PREFILL  = 2'd1;
    localparam logic [1:0] ST_RUN      = 2'd2;

    localparam logic [13:0] IDLE_CODE = 14'h1FFF;

    // offset-binary, inverted: signed 0 maps to mid-scale 0x1FFF
    function automatic logic [13:0] to_dac_code(input logic [13:0] s);
        return {s[13], ~s[12:0]};
    endfunction

    // clamp a signed 16-bit half to the 14-bit signed range
    function automatic logic [13:0] sat14(input logic [15:0] x);
        return ($signed(x) > 16'sd8191) ? 14'h1FFF :
               ($signed(x) < -16'sd8192) ? 14'h2000 : x[13:0];
    endfunction

endpackage

// File: rtl/axis_red_pitaya_dac_tx_fifo.sv
// axis_dac_fifo: synchronous FIFO, extra pointer bit separates full from empty
module axis_dac_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;

    assign count = wr_ptr - rd_ptr;
    assign full  = count == (AW+1)'(DEPTH);
    assign empty = wr_ptr == rd_ptr;
    assign dout  = mem[rd_ptr[AW-1:0]];

    // storage needs no reset; the pointers alone define valid content
    always_ff @(posedge clk)
        if (push) mem[wr_ptr[AW-1:0]] <= din;

    // pointer advance; reset flushes the buffer
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
        end

endmodule

// File: rtl/axis_red_pitaya_dac_tx.sv
// axis_red_pitaya_dac_tx: AXI4-Stream to Red Pitaya dual DAC with prefill, reset hold and underflow count
// Define AXIS_RED_PITAYA_DAC_TX_SATURATE_EN to clamp each 16-bit half instead of truncating it.
module axis_red_pitaya_dac_tx
    import axis_red_pitaya_dac_pkg::*;
#(
    parameter int DAC_DATA_WIDTH   = 14,
    parameter int AXIS_TDATA_WIDTH = 32,
    parameter int FIFO_DEPTH       = 16,
    parameter int PREFILL          = 8,
    parameter int RESET_CYCLES     = 16
) (
    input  logic                        aclk,
    input  logic                        areset,
    input  logic [AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
    input  logic                        s_axis_tvalid,
    output logic                        s_axis_tready,
    output logic [DAC_DATA_WIDTH-1:0]   dac_dat_a,
    output logic [DAC_DATA_WIDTH-1:0]   dac_dat_b,
    output logic                        dac_rst,
    output logic                        running,
    output logic [31:0]                 underflow_cnt
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int HW = AXIS_TDATA_WIDTH / 2;
    localparam int CW = $clog2(RESET_CYCLES + 1);

    logic [1:0]                  state;
    logic [CW-1:0]               hold_cnt;
    logic [AXIS_TDATA_WIDTH-1:0] head;
    logic                        full;
    logic                        empty;
    logic [AW:0]                 count;
    logic                        push;
    logic                        pop;
    logic [13:0]                 s_a;
    logic [13:0]                 s_b;

    assign s_axis_tready = state != ST_RST_HOLD && !full;
    assign push          = s_axis_tvalid && s_axis_tready;
    assign pop           = state == ST_RUN && !empty;
    assign running       = state == ST_RUN;

`ifdef AXIS_RED_PITAYA_DAC_TX_SATURATE_EN
    assign s_a = sat14(head[HW-1:0]);
    assign s_b = sat14(head[2*HW-1:HW]);
`else
    logic unused_upper;
    assign unused_upper = ^{head[HW-1:14], head[2*HW-1:HW+14]};
    assign s_a = head[13:0];
    assign s_b = head[HW+13:HW];
`endif

    axis_dac_fifo #(
        .WIDTH(AXIS_TDATA_WIDTH),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk  (aclk),
        .rst  (areset),
        .push (push),
        .pop  (pop),
        .din  (s_axis_tdata),
        .dout (head),
        .full (full),
        .empty(empty),
        .count(count)
    );

    // startup hold, prefill gate, and playout with underflow recovery
    always_ff @(posedge aclk or posedge areset)
        if (areset) begin
            state         <= ST_RST_HOLD;
            hold_cnt      <= '0;
            dac_rst       <= 1'b1;
            dac_dat_a     <= IDLE_CODE;
            dac_dat_b     <= IDLE_CODE;
            underflow_cnt <= '0;
        end else if (state == ST_RST_HOLD) begin
            hold_cnt <= hold_cnt + 1'b1;
            if (hold_cnt == CW'(RESET_CYCLES - 1)) begin
                dac_rst <= 1'b0;
                state   <= ST_PREFILL;
            end
        end else if (state == ST_PREFILL) begin
            if (count >= (AW+1)'(PREFILL)) state <= ST_RUN;
        end else if (pop) begin
            dac_dat_a <= to_dac_code(s_a);
            dac_dat_b <= to_dac_code(s_b);
        end else begin
            dac_dat_a <= IDLE_CODE;
            dac_dat_b <= IDLE_CODE;
            if (underflow_cnt != '1) underflow_cnt <= underflow_cnt + 32'd1;
            state <= ST_PREFILL;
        end

endmodule

// File: tb/tb_axis_red_pitaya_dac_tx.sv
// tb_axis_red_pitaya_dac_tx: scoreboard bench with a queue-based reference model
module tb_axis_red_pitaya_dac_tx;

    localparam int DEPTH = 16;
    localparam int PRE   = 8;
    localparam int RC    = 16;
    localparam logic [13:0] IDLE = 14'h1FFF;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] tdata = '0;
    logic        tvalid = 1'b0;
    logic        tready;
    logic [13:0] dac_a;
    logic [13:0] dac_b;
    logic        dac_rst;
    logic        running;
    logic [31:0] ucnt;

    logic        rst_bp = 1'b1;
    logic [31:0] bp_tdata = '0;
    logic        bp_tvalid = 1'b0;
    logic        bp_tready;
    logic [13:0] bp_a;
    logic [13:0] bp_b;
    logic        bp_dac_rst;
    logic        bp_running;
    logic [31:0] bp_ucnt;
    logic        bp_done = 1'b0;

    int compared = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    axis_red_pitaya_dac_tx dut (
        .aclk(clk), .areset(rst), .s_axis_tdata(tdata), .s_axis_tvalid(tvalid),
        .s_axis_tready(tready), .dac_dat_a(dac_a), .dac_dat_b(dac_b),
        .dac_rst(dac_rst), .running(running), .underflow_cnt(ucnt)
    );

    axis_red_pitaya_dac_tx #(.PREFILL(DEPTH)) dut_bp (
        .aclk(clk), .areset(rst_bp), .s_axis_tdata(bp_tdata), .s_axis_tvalid(bp_tvalid),
        .s_axis_tready(bp_tready), .dac_dat_a(bp_a), .dac_dat_b(bp_b),
        .dac_rst(bp_dac_rst), .running(bp_running), .underflow_cnt(bp_ucnt)
    );

    // expected DAC code: mid-scale minus the signed sample value
    function automatic logic [13:0] code(input logic [15:0] h);
        int v;
`ifdef AXIS_RED_PITAYA_DAC_TX_SATURATE_EN
        v = int'($signed(h));
        if (v > 8191) v = 8191;
        if (v < -8192) v = -8192;
`else
        v = int'(h & 16'h3FFF);
        if (v >= 8192) v -= 16384;
`endif
        return 14'(8191 - v);
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        compared++;
        if (got !== want) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
        end
    endtask

    function automatic logic [31:0] rand_word();
        logic [15:0] edges [6] = '{16'h0000, 16'h1FFF, 16'h2000, 16'h7FFF, 16'h8000, 16'hFFFF};
        logic [15:0] lo;
        logic [15:0] hi;
        lo = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 5)] : 16'($urandom);
        hi = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 5)] : 16'($urandom);
        return {hi, lo};
    endfunction

    typedef struct {
        logic [13:0] a;
        logic [13:0] b;
        logic        dr;
        logic        run;
        logic        rdy;
        logic [31:0] u;
    } exp_t;

    exp_t        expq[$];
    logic [31:0] mq[$];
    int          hold_left;
    bit          run_m;
    logic [31:0] ucnt_m;
    logic [13:0] a_m;
    logic [13:0] b_m;
    bit          rdy_m;
    logic [31:0] w_m;

    // reference model: hold countdown, prefill threshold, one pop per cycle in run
    always @(posedge clk) begin
        if (rst) begin
            mq.delete();
            hold_left = RC;
            run_m = 0;
            ucnt_m = '0;
            a_m = IDLE;
            b_m = IDLE;
        end else begin
            rdy_m = hold_left == 0 && mq.size() < DEPTH;
            if (hold_left > 0) hold_left--;
            else if (!run_m) begin
                if (mq.size() >= PRE) run_m = 1;
            end else if (mq.size() > 0) begin
                w_m = mq.pop_front();
                a_m = code(w_m[15:0]);
                b_m = code(w_m[31:16]);
            end else begin
                a_m = IDLE;
                b_m = IDLE;
                if (ucnt_m != 32'hFFFF_FFFF) ucnt_m++;
                run_m = 0;
            end
            if (tvalid && rdy_m) mq.push_back(tdata);
            expq.push_back('{a_m, b_m, hold_left > 0, run_m, hold_left == 0 && mq.size() < DEPTH, ucnt_m});
        end
    end

    exp_t e;

    // monitor: compare DUT pins against the scoreboard each cycle
    always @(posedge clk) begin
        #1;
        if (rst)
            chk("reset_state", {1'b0, dac_a, dac_b, dac_rst, running, tready, ucnt},
                {1'b0, IDLE, IDLE, 1'b1, 1'b0, 1'b0, 32'd0});
        else if (expq.size() == 0)
            chk("scoreboard_empty", 64'd0, 64'd1);
        else begin
            e = expq.pop_front();
            chk("pins", {1'b0, dac_a, dac_b, dac_rst, running, tready, ucnt},
                {1'b0, e.a, e.b, e.dr, e.run, e.rdy, e.u});
        end
    end

    task automatic idle(input int n);
        tvalid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input logic [31:0] w);
        int n = 0;
        tdata = w;
        tvalid = 1'b1;
        while (!tready && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("send_accept", 64'(n < 200), 64'd1);
        @(negedge clk);
        tvalid = 1'b0;
    endtask

    task automatic random_phase(input int cycles, input int pct);
        repeat (cycles) begin
            tvalid = $urandom_range(0, 99) < pct;
            tdata = rand_word();
            @(negedge clk);
        end
        tvalid = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        idle(20);
        repeat (7) send(rand_word());
        idle(5);
        send(rand_word());
        idle(20);
        send({16'h2000, 16'h1FFF});
        send(32'h0000_0000);
        repeat (6) send(rand_word());
        idle(20);
        repeat (8) send(rand_word());
        idle(20);
        repeat (8) send(rand_word());
        idle(20);
        send({16'h8000, 16'h7FFF});
        repeat (7) send(rand_word());
        idle(20);
        random_phase(1500, 60);
        random_phase(30, 100);
        rst = 1'b1;
        idle(3);
        rst = 1'b0;
        idle(25);
        random_phase(800, 95);
        idle(30);
        for (int i = 0; i < 2000 && !bp_done; i++) @(negedge clk);
        chk("bp_done", 64'(bp_done), 64'd1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    logic [31:0] bpq[$];
    logic [31:0] bp_exp;

    // backpressure instance: prefill equals depth, so the FIFO must fill before playout
    initial begin
        int n;
        int pushes;
        n = 0;
        pushes = 0;
        repeat (3) @(negedge clk);
        rst_bp = 1'b0;
        while (!bp_tready && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("bp_ready_after_hold", {63'd0, bp_tready}, 64'd1);
        bp_tvalid = 1'b1;
        n = 0;
        while (pushes < DEPTH && n < 200) begin
            bp_tdata = {16'(pushes * 37), 16'(16'h7FF0 + pushes)};
            if (bp_tready) begin
                bpq.push_back(bp_tdata);
                pushes++;
            end
            @(negedge clk);
            n++;
        end
        chk("bp_full_tready_running", {62'd0, bp_tready, bp_running}, 64'd0);
        @(negedge clk);
        chk("bp_run_entry", {62'd0, bp_tready, bp_running}, 64'd1);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            bp_exp = bpq.pop_front();
            chk("bp_stream", {34'd0, bp_tready, bp_running, bp_a, bp_b},
                {34'd0, 1'b1, 1'b1, code(bp_exp[15:0]), code(bp_exp[31:16])});
            bp_tdata = {16'($urandom), 16'($urandom)};
            bpq.push_back(bp_tdata);
        end
        bp_tvalid = 1'b0;
        bp_done = 1'b1;
    end

endmodule
